// File: rtl/sram_arbiter_if.sv
// Bundle of fetch port, data port and SRAM pins shared by the arbiter and its environment.
// Handshake: a requester raises *_req_i with stable attributes and holds it until the matching
// *_ack_o, which is a single-cycle completion pulse; read data is valid only while ack is high.
interface sram_arbiter_if #(
   parameter int SRAM_AW = 20
);
   logic               if_req_i;
   logic [31:0]        if_addr_i;
   logic [31:0]        if_rdata_o;
   logic               if_ack_o;
   logic               dm_req_i;
   logic               dm_we_i;
   logic [31:0]        dm_addr_i;
   logic [3:0]         dm_wbe_n_i;
   logic [31:0]        dm_wdata_i;
   logic [31:0]        dm_rdata_o;
   logic               dm_ack_o;
   logic [SRAM_AW-1:0] sram_addr_o;
   logic [31:0]        sram_wdata_o;
   logic [31:0]        sram_rdata_i;
   logic [3:0]         sram_be_n_o;
   logic               sram_ce_n_o;
   logic               sram_oe_n_o;
   logic               sram_we_n_o;
   logic               arb_busy_o;

   modport slave (
      input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
             sram_rdata_i,
      output if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, sram_addr_o, sram_wdata_o,
             sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, arb_busy_o
   );

   modport master (
      output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wbe_n_i, dm_wdata_i,
             sram_rdata_i,
      input  if_rdata_o, if_ack_o, dm_rdata_o, dm_ack_o, sram_addr_o, sram_wdata_o,
             sram_be_n_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, arb_busy_o
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (fetch / data) arbiter onto a single asynchronous SRAM with fixed wait states.
// Each access is IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RECOVER (ack), all outputs registered.
module sram_arbiter #(
   parameter int WAIT_CYCLES = 1,
   parameter int SRAM_AW     = 20
) (
   input  logic           clk,
   input  logic           rst_n,
   sram_arbiter_if.slave  bus,
   output logic [1:0]     o_dbg_state
);
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_RECOVER = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic               r_last_dm;
   logic               r_gnt_dm;
   logic               r_store;
   logic               r_busy;
   logic [SRAM_AW-1:0] r_addr;
   logic [31:0]        r_wdata;
   logic [31:0]        r_if_rdata;
   logic [31:0]        r_dm_rdata;
   logic [3:0]         r_be_n;
   logic               r_ce_n;
   logic               r_oe_n;
   logic               r_we_n;
   logic               r_if_ack;
   logic               r_dm_ack;
   logic               w_any_req;
   logic               w_grant_dm;
   logic               w_store;
   logic [31:0]        w_sel_addr;
   logic               w_unused;

   // On contention the port that did not win last time gets the SRAM.
   assign w_any_req  = bus.if_req_i | bus.dm_req_i;
   assign w_grant_dm = bus.dm_req_i & (~bus.if_req_i | ~r_last_dm);
   assign w_store    = w_grant_dm & bus.dm_we_i;
   assign w_sel_addr = w_grant_dm ? bus.dm_addr_i : bus.if_addr_i;
   assign w_unused   = ^{w_sel_addr[31:SRAM_AW+2], w_sel_addr[1:0]};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:    if (w_any_req) w_state_nxt = ST_ACCESS;
         ST_ACCESS:  if (r_cnt == 4'd0) w_state_nxt = ST_RECOVER;
         ST_RECOVER: w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != ST_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= 4'd0;
         r_last_dm  <= 1'b0;
         r_gnt_dm   <= 1'b0;
         r_store    <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_if_rdata <= 32'h0;
         r_dm_rdata <= 32'h0;
         r_be_n     <= 4'hf;
         r_ce_n     <= 1'b1;
         r_oe_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_if_ack   <= 1'b0;
         r_dm_ack   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_gnt_dm  <= w_grant_dm;
                  r_last_dm <= w_grant_dm;
                  r_store   <= w_store;
                  r_addr    <= w_sel_addr[SRAM_AW+1:2];
                  r_cnt     <= 4'(WAIT_CYCLES);
                  r_ce_n    <= 1'b0;
                  r_oe_n    <= w_store;
                  r_we_n    <= ~w_store;
                  r_be_n    <= w_store ? bus.dm_wbe_n_i : 4'h0;
                  if (w_store) r_wdata <= bus.dm_wdata_i;
               end
            end
            ST_ACCESS: begin
               if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  if (!r_store) begin
                     if (r_gnt_dm) r_dm_rdata <= bus.sram_rdata_i;
                     else          r_if_rdata <= bus.sram_rdata_i;
                  end
                  r_ce_n   <= 1'b1;
                  r_oe_n   <= 1'b1;
                  r_we_n   <= 1'b1;
                  r_be_n   <= 4'hf;
                  r_if_ack <= ~r_gnt_dm;
                  r_dm_ack <= r_gnt_dm;
               end
            end
            ST_RECOVER: begin
               r_if_ack <= 1'b0;
               r_dm_ack <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.if_rdata_o   = r_if_rdata;
   assign bus.if_ack_o     = r_if_ack;
   assign bus.dm_rdata_o   = r_dm_rdata;
   assign bus.dm_ack_o     = r_dm_ack;
   assign bus.sram_addr_o  = r_addr;
   assign bus.sram_wdata_o = r_wdata;
   assign bus.sram_be_n_o  = r_be_n;
   assign bus.sram_ce_n_o  = r_ce_n;
   assign bus.sram_oe_n_o  = r_oe_n;
   assign bus.sram_we_n_o  = r_we_n;
   assign bus.arb_busy_o   = r_busy;
   assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed timing/arbitration/reset scenarios plus a randomized
// two-port mix checked against a word-level memory model updated in ack order.
module tb_sram_arbiter;
  localparam int W  = 1;
  localparam int AW = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  sram_arbiter_if #(.SRAM_AW(AW)) bus1 ();
  sram_arbiter_if #(.SRAM_AW(AW)) bus0 ();
  logic [1:0] state_unused1;
  logic [1:0] state_unused0;

  sram_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus1), .o_dbg_state(state_unused1));
  sram_arbiter #(.WAIT_CYCLES(0), .SRAM_AW(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .o_dbg_state(state_unused0));

  // SRAM model for dut (byte-enabled writes, reads only while selected and output-enabled)
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = 8'h0;
  logic [31:0] pre_data = 32'h0;
  logic [31:0] exp_dm_rd = 32'h0;

  assign bus1.sram_rdata_i = (!bus1.sram_ce_n_o && !bus1.sram_oe_n_o) ?
                             mem[bus1.sram_addr_o[7:0]] : 32'h0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!bus1.sram_ce_n_o && !bus1.sram_we_n_o)
      for (int b = 0; b < 4; b++)
        if (!bus1.sram_be_n_o[b]) mem[bus1.sram_addr_o[7:0]][8*b +: 8] <= bus1.sram_wdata_o[8*b +: 8];
  end

  // dut0 sees an address-derived pattern so its data is predictable without storage
  assign bus0.sram_rdata_i = (!bus0.sram_ce_n_o && !bus0.sram_oe_n_o) ?
                             {8'hC3, 4'h0, bus0.sram_addr_o} : 32'h0;

  always @(negedge clk) begin
    if (bus1.if_ack_o || bus1.dm_ack_o) begin
      total++;
      if (bus1.if_ack_o && bus1.dm_ack_o) begin
        bad++; $display("FAIL ack_overlap dut got both acks high at %0t", $time);
      end
    end
    if (bus0.if_ack_o || bus0.dm_ack_o) begin
      total++;
      if (bus0.if_ack_o && bus0.dm_ack_o) begin
        bad++; $display("FAIL ack_overlap dut0 got both acks high at %0t", $time);
      end
    end
  end

  task automatic preload();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = (i < 16) ? 8'(i) : 8'h40;
      pre_data = (i == 4) ? 32'hDEADBEEF : $urandom;
      ref_mem[pre_addr] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({bus1.sram_ce_n_o, bus1.sram_oe_n_o, bus1.sram_we_n_o, bus1.sram_be_n_o} !== 7'h7f) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=1111111",
        {bus1.sram_ce_n_o, bus1.sram_oe_n_o, bus1.sram_we_n_o, bus1.sram_be_n_o});
    end
    total++;
    if ({bus1.if_ack_o, bus1.dm_ack_o, bus1.arb_busy_o} !== 3'b000) begin
      bad++; $display("FAIL reset_ack_busy got=%b exp=000",
        {bus1.if_ack_o, bus1.dm_ack_o, bus1.arb_busy_o});
    end
    total++;
    if ({bus1.if_rdata_o, bus1.dm_rdata_o} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0", {bus1.if_rdata_o, bus1.dm_rdata_o});
    end
    total++;
    if (bus1.sram_addr_o !== 20'h0 || bus1.sram_wdata_o !== 32'h0) begin
      bad++; $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", bus1.sram_addr_o, bus1.sram_wdata_o);
    end
  endtask

  task automatic test_contention();
    int port_q[$];
    int cyc_q[$];
    @(negedge clk);
    bus1.dm_addr_i = 32'h8; bus1.dm_we_i = 1'b0; bus1.if_addr_i = 32'h14;
    bus1.dm_req_i = 1'b1; bus1.if_req_i = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus1.dm_ack_o) begin
        port_q.push_back(1); cyc_q.push_back(c); total++;
        if (bus1.dm_rdata_o !== ref_mem[2]) begin
          bad++; $display("FAIL contention_dm_data got=%h exp=%h", bus1.dm_rdata_o, ref_mem[2]);
        end
      end
      if (bus1.if_ack_o) begin
        port_q.push_back(0); cyc_q.push_back(c); total++;
        if (bus1.if_rdata_o !== ref_mem[5]) begin
          bad++; $display("FAIL contention_if_data got=%h exp=%h", bus1.if_rdata_o, ref_mem[5]);
        end
      end
      if (port_q.size() == 4) break;
    end
    bus1.dm_req_i = 1'b0; bus1.if_req_i = 1'b0;
    exp_dm_rd = ref_mem[2];
    total++;
    if (port_q.size() != 4) begin
      bad++; $display("FAIL contention_count got=%0d exp=4", port_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (port_q[i] != ((i % 2 == 0) ? 1 : 0)) begin
          bad++; $display("FAIL contention_order idx=%0d got_dm=%0d exp_dm=%0d", i, port_q[i], (i % 2 == 0));
        end
        total++;
        if (cyc_q[i] != ((i == 0) ? W + 2 : cyc_q[i-1] + W + 3)) begin
          bad++; $display("FAIL contention_timing idx=%0d got=%0d exp=%0d", i, cyc_q[i],
            (i == 0) ? W + 2 : cyc_q[i-1] + W + 3);
        end
      end
    end
  endtask

  task automatic test_if_read();
    int oe_low = 0;
    int ack_cyc = -1;
    int ack_cnt = 0;
    logic [19:0] a1 = '0;
    logic [19:0] a2 = '0;
    logic [31:0] rd = '0;
    @(negedge clk);
    bus1.if_addr_i = 32'h10; bus1.if_req_i = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) begin a1 = bus1.sram_addr_o; bus1.if_addr_i = 32'h20; end
      if (c == 2) a2 = bus1.sram_addr_o;
      if (!bus1.sram_oe_n_o) oe_low++;
      if (bus1.if_ack_o) begin
        ack_cnt++;
        if (ack_cyc < 0) begin ack_cyc = c; rd = bus1.if_rdata_o; end
        bus1.if_req_i = 1'b0;
      end
    end
    total++;
    if (a1 !== 20'h4 || a2 !== 20'h4) begin
      bad++; $display("FAIL if_read_addr got=%h,%h exp=4", a1, a2);
    end
    total++;
    if (oe_low != W + 1) begin bad++; $display("FAIL if_read_oe_cycles got=%0d exp=%0d", oe_low, W + 1); end
    total++;
    if (ack_cyc != W + 2 || ack_cnt != 1) begin
      bad++; $display("FAIL if_read_ack got_cyc=%0d got_cnt=%0d exp_cyc=%0d exp_cnt=1", ack_cyc, ack_cnt, W + 2);
    end
    total++;
    if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL if_read_data got=%h exp=deadbeef", rd); end
    total++;
    if (bus1.arb_busy_o !== 1'b0) begin bad++; $display("FAIL if_read_idle_busy got=%b exp=0", bus1.arb_busy_o); end
  endtask

  task automatic test_store();
    for (int k = 0; k < 2; k++) begin
      logic [3:0]  be = (k == 0) ? 4'b0111 : 4'b1111;
      logic [31:0] wd = (k == 0) ? 32'hAB000000 : 32'h12345678;
      int we_low = 0;
      int ack_cyc = -1;
      int ack_cnt = 0;
      logic [19:0] a1 = '0;
      logic [3:0]  be1 = '0;
      logic [31:0] wd1 = '0;
      @(negedge clk);
      bus1.dm_we_i = 1'b1; bus1.dm_addr_i = 32'h103; bus1.dm_wbe_n_i = be;
      bus1.dm_wdata_i = wd; bus1.dm_req_i = 1'b1;
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        if (c == 1) begin
          a1 = bus1.sram_addr_o; be1 = bus1.sram_be_n_o; wd1 = bus1.sram_wdata_o;
          bus1.dm_wdata_i = 32'h0; bus1.dm_wbe_n_i = 4'h0;
        end
        if (!bus1.sram_we_n_o && !bus1.sram_ce_n_o) we_low++;
        if (bus1.dm_ack_o) begin
          ack_cnt++;
          if (ack_cyc < 0) ack_cyc = c;
          bus1.dm_req_i = 1'b0;
        end
      end
      for (int b = 0; b < 4; b++) if (!be[b]) ref_mem[8'h40][8*b +: 8] = wd[8*b +: 8];
      total++;
      if (a1 !== 20'h40 || be1 !== be || wd1 !== wd) begin
        bad++; $display("FAIL store_bus k=%0d got=%h/%b/%h exp=40/%b/%h", k, a1, be1, wd1, be, wd);
      end
      total++;
      if (we_low != W + 1) begin bad++; $display("FAIL store_we_cycles k=%0d got=%0d exp=%0d", k, we_low, W + 1); end
      total++;
      if (ack_cyc != W + 2 || ack_cnt != 1) begin
        bad++; $display("FAIL store_ack k=%0d got_cyc=%0d got_cnt=%0d exp_cyc=%0d exp_cnt=1", k, ack_cyc, ack_cnt, W + 2);
      end
      total++;
      if (bus1.dm_rdata_o !== exp_dm_rd) begin
        bad++; $display("FAIL store_rdata_hold k=%0d got=%h exp=%h", k, bus1.dm_rdata_o, exp_dm_rd);
      end
      total++;
      if (mem[8'h40] !== ref_mem[8'h40]) begin
        bad++; $display("FAIL store_mem k=%0d got=%h exp=%h", k, mem[8'h40], ref_mem[8'h40]);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int ack_cnt = 0;
    int ack_cyc = -1;
    @(negedge clk);
    bus1.dm_we_i = 1'b1; bus1.dm_addr_i = 32'h30; bus1.dm_wbe_n_i = 4'h0;
    bus1.dm_wdata_i = $urandom; bus1.dm_req_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus1.sram_we_n_o !== 1'b0) begin bad++; $display("FAIL midrst_pre_we got=%b exp=0", bus1.sram_we_n_o); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus1.sram_we_n_o, bus1.sram_ce_n_o, bus1.arb_busy_o, bus1.dm_ack_o} !== 4'b1100) begin
      bad++; $display("FAIL midrst_async got=%b exp=1100",
        {bus1.sram_we_n_o, bus1.sram_ce_n_o, bus1.arb_busy_o, bus1.dm_ack_o});
    end
    bus1.dm_req_i = 1'b0;
    exp_dm_rd = 32'h0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus1.dm_ack_o) ack_cnt++;
    end
    total++;
    if (ack_cnt != 0) begin bad++; $display("FAIL midrst_no_ack got=%0d exp=0", ack_cnt); end
    bus1.dm_we_i = 1'b0; bus1.dm_addr_i = 32'hC; bus1.dm_req_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus1.dm_ack_o) begin ack_cyc = c; exp_dm_rd = ref_mem[3]; break; end
    end
    bus1.dm_req_i = 1'b0;
    total++;
    if (ack_cyc != W + 2 || bus1.dm_rdata_o !== ref_mem[3]) begin
      bad++; $display("FAIL midrst_after got_cyc=%0d got=%h exp_cyc=%0d exp=%h", ack_cyc, bus1.dm_rdata_o, W + 2, ref_mem[3]);
    end
  endtask

  task automatic test_wait0();
    int oe_low = 0;
    int ack_cyc = -1;
    int cyc_q[$];
    logic [31:0] rd = '0;
    @(negedge clk);
    bus0.if_addr_i = 32'h24; bus0.if_req_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (!bus0.sram_oe_n_o) oe_low++;
      if (bus0.if_ack_o && ack_cyc < 0) begin ack_cyc = c; rd = bus0.if_rdata_o; bus0.if_req_i = 1'b0; end
    end
    total++;
    if (ack_cyc != 2 || oe_low != 1) begin
      bad++; $display("FAIL wait0_read_timing got_cyc=%0d got_oe=%0d exp=2/1", ack_cyc, oe_low);
    end
    total++;
    if (rd !== 32'hC3000009) begin bad++; $display("FAIL wait0_read_data got=%h exp=c3000009", rd); end
    bus0.dm_we_i = 1'b0; bus0.dm_addr_i = 32'h40; bus0.dm_req_i = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus0.dm_ack_o) begin
        total++;
        if (bus0.dm_rdata_o !== {8'hC3, 4'h0, bus0.dm_addr_i[21:2]}) begin
          bad++; $display("FAIL wait0_load_data got=%h exp=%h", bus0.dm_rdata_o, {8'hC3, 4'h0, bus0.dm_addr_i[21:2]});
        end
        cyc_q.push_back(c);
        bus0.dm_addr_i = bus0.dm_addr_i + 32'h4;
        if (cyc_q.size() == 3) break;
      end
    end
    bus0.dm_req_i = 1'b0;
    total++;
    if (cyc_q.size() != 3) begin
      bad++; $display("FAIL wait0_b2b_count got=%0d exp=3", cyc_q.size());
    end else begin
      total++;
      if (cyc_q[0] != 2 || cyc_q[1] - cyc_q[0] != 3 || cyc_q[2] - cyc_q[1] != 3) begin
        bad++; $display("FAIL wait0_b2b_spacing got=%0d,%0d,%0d exp=2,5,8", cyc_q[0], cyc_q[1], cyc_q[2]);
      end
    end
  endtask

  task automatic test_random();
    fork
      begin : if_drv
        int t;
        int wd;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          wd = $urandom_range(0, 15);
          bus1.if_addr_i = 32'(wd * 4 + $urandom_range(0, 3));
          bus1.if_req_i = 1'b1;
          for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus1.if_ack_o) break;
          end
          bus1.if_req_i = 1'b0;
          total++;
          if (t == 40) begin
            bad++; $display("FAIL rand_if_timeout n=%0d got=no_ack exp=ack", n);
          end else if (bus1.if_rdata_o !== ref_mem[wd]) begin
            bad++; $display("FAIL rand_if_data n=%0d got=%h exp=%h", n, bus1.if_rdata_o, ref_mem[wd]);
          end
        end
      end
      begin : dm_drv
        int t;
        int wd;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          wd = $urandom_range(0, 15);
          bus1.dm_addr_i  = 32'(wd * 4 + $urandom_range(0, 3));
          bus1.dm_we_i    = 1'($urandom_range(0, 1));
          bus1.dm_wbe_n_i = 4'($urandom_range(0, 15));
          bus1.dm_wdata_i = $urandom;
          bus1.dm_req_i   = 1'b1;
          for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus1.dm_ack_o) break;
          end
          bus1.dm_req_i = 1'b0;
          total++;
          if (t == 40) begin
            bad++; $display("FAIL rand_dm_timeout n=%0d got=no_ack exp=ack", n);
          end else if (bus1.dm_we_i) begin
            for (int b = 0; b < 4; b++)
              if (!bus1.dm_wbe_n_i[b]) ref_mem[wd][8*b +: 8] = bus1.dm_wdata_i[8*b +: 8];
            if (bus1.dm_rdata_o !== exp_dm_rd) begin
              bad++; $display("FAIL rand_dm_store_hold n=%0d got=%h exp=%h", n, bus1.dm_rdata_o, exp_dm_rd);
            end
          end else begin
            exp_dm_rd = ref_mem[wd];
            if (bus1.dm_rdata_o !== ref_mem[wd]) begin
              bad++; $display("FAIL rand_dm_load n=%0d got=%h exp=%h", n, bus1.dm_rdata_o, ref_mem[wd]);
            end
          end
        end
      end
    join
  endtask

  initial begin
    bus1.if_req_i = 1'b0; bus1.if_addr_i = 32'h0; bus1.dm_req_i = 1'b0; bus1.dm_we_i = 1'b0;
    bus1.dm_addr_i = 32'h0; bus1.dm_wbe_n_i = 4'hf; bus1.dm_wdata_i = 32'h0;
    bus0.if_req_i = 1'b0; bus0.if_addr_i = 32'h0; bus0.dm_req_i = 1'b0; bus0.dm_we_i = 1'b0;
    bus0.dm_addr_i = 32'h0; bus0.dm_wbe_n_i = 4'hf; bus0.dm_wdata_i = 32'h0;
    #2 rst_n = 1'b0;
    test_reset();
    preload();
    @(negedge clk);
    rst_n = 1'b1;
    test_contention();
    test_if_read();
    test_store();
    test_reset_mid_access();
    test_wait0();
    test_random();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
